data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the MEM-stage control bundle: mem_enable, mem_rw, mem_size, mem_se, plus address and store data from the EX/MEM register.
- Byte-addressed, big-endian data RAM. Configurable wait states. Drives a busy/ready handshake so the pipeline control can stall MEM.
- Returns load data sized and sign/zero-extended for the MEM/WB register. Flags misaligned accesses.

Parameters:
- ADDR_WIDTH, 9, number of address bits decoded; RAM holds 2**ADDR_WIDTH bytes.
- WAIT_STATES, 2, number of stall cycles inserted before each access completes (0 allowed).

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous, active-low.
- mem_enable  input  1  request valid, sampled only in IDLE.
- mem_rw  input  1  0 = load, 1 = store.
- mem_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- mem_se  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- address  input  32  byte address; bits above ADDR_WIDTH-1 are ignored (address wraps).
- data_in  input  32  store data, right-justified.
- data_out  output  32  load result, registered.
- mem_busy  output  1  request accepted, access not yet complete.
- mem_ready  output  1  one-cycle completion pulse.
- mem_err  output  1  high with mem_ready when the request was misaligned or illegal.

Behaviour:
- **States:** IDLE, WAIT, DONE, ERR. Outputs are registered or decoded from state only.
- **Reset** (reset=0 at a rising edge):
  - state = IDLE; data_out = 0; mem_busy = 0; mem_ready = 0; mem_err = 0; wait counter = 0.
  - RAM contents are not cleared.
  - Reset has priority over every transition, including a pending commit.
- **IDLE:**
  - mem_enable=0: stay in IDLE.
  - mem_enable=1: latch address, data_in, mem_size, mem_se, mem_rw.
  - Misaligned/illegal request goes to ERR. Misaligned/illegal means: halfword with address[0]=1; word with address[1:0]≠00; or mem_size=11.
  - Otherwise, with WAIT_STATES>0: go to WAIT, counter = WAIT_STATES-1.
  - Otherwise, with WAIT_STATES=0: perform the access at this edge and go to DONE.
- **WAIT:**
  - mem_busy=1.
  - Counter >0: decrement.
  - Counter =0: perform the access at this edge and go to DONE.
  - Inputs are ignored while in WAIT; only the latched copies are used.
- **Access, performed at the edge entering DONE, using latched values:**
  - Store byte: mem[a] = d[7:0].
  - Store halfword: mem[a] = d[15:8]; mem[a+1] = d[7:0].
  - Store word: mem[a..a+3] = d[31:24], d[23:16], d[15:8], d[7:0].
  - Load byte: data_out = the byte at mem[a], extended to 32 bits.
  - Load halfword: data_out = {mem[a], mem[a+1]}, extended to 32 bits.
  - Load word: data_out = {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
  - Extension for byte/halfword loads: sign-extended when se=1, zero-extended when se=0.
  - A store leaves data_out unchanged.
- **DONE:** mem_ready=1, mem_busy=0, mem_err=0 for exactly one cycle, then IDLE.
- **ERR:** mem_ready=1, mem_err=1 for exactly one cycle, then IDLE. No RAM access; data_out unchanged. Takes 1 cycle regardless of WAIT_STATES.
- **Timing:**
  - Request sampled at the end of cycle t.
  - mem_busy is high for cycles t+1 .. t+WAIT_STATES.
  - mem_ready is high in cycle t+WAIT_STATES+1.
  - data_out is valid from the ready cycle and holds until the next load completes.
- **Back-to-back:** the cycle after DONE/ERR is IDLE. mem_enable still high there is a new request; the initiator must advance or drop it.
- **Address wrap:** aligned accesses never cross the top of RAM. Addresses wrap modulo 2**ADDR_WIDTH.
- **Reset mid-operation:** the request is abandoned and no write is committed. mem_ready is never pulsed for it.

Test Plan:
1. Reset held low for 2 cycles with mem_enable=1 -> mem_busy=0, mem_ready=0, mem_err=0, data_out=0; no access starts until reset=1.
2. WAIT_STATES=2: store word 0xDEADBEEF @0x10, then load word @0x10 -> each request shows busy for 2 cycles and ready on the 3rd cycle after sampling; load gives data_out=0xDEADBEEF.
3. Sized loads after step 2:
   - Byte @0x10, se=1 -> 0xFFFFFFDE.
   - Byte @0x10, se=0 -> 0x000000DE.
   - Half @0x12, se=1 -> 0xFFFFBEEF.
   - Half @0x12, se=0 -> 0x0000BEEF.
4. Store byte 0x5A @0x13, then load word @0x10 -> 0xDEADBE5A. Store half 0x1234 @0x10, then load word @0x10 -> 0x1234BE5A.
5. Load word @0x12; store half @0x11; load with size=11 @0x10 -> each gives ready=1 and err=1 one cycle after sampling, busy never high, data_out unchanged; load word @0x10 still returns 0x1234BE5A.
6. Store word 0 @0x20; store word 0x11111111 @0x20 with reset=0 during WAIT -> no ready pulse; after reset release, load word @0x20 returns 0x00000000. Load @(0x20 + 2**ADDR_WIDTH) also returns 0x00000000 (wrap).

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-side responder for the MEM stage: a byte-addressed, big-endian data
// RAM with a configurable number of wait states and a busy/ready handshake.
// Load results are sized and sign/zero-extended for the MEM/WB register, and
// misaligned or illegal requests complete with an error pulse and no access.

module data_mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_enable,
  input  logic        mem_rw,
  input  logic [1:0]  mem_size,
  input  logic        mem_se,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        mem_busy,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // The counter only ever holds WAIT_STATES-1 down to 0.
  localparam int CW    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_t;

  state_t                  state;
  logic [CW-1:0]           wait_cnt;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [31:0]             lat_data;
  logic [1:0]              lat_size;
  logic                    lat_se;
  logic                    lat_rw;

  logic [7:0]              ram [DEPTH];

  logic                    misaligned_req;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [31:0]             acc_data;
  logic [1:0]              acc_size;
  logic                    acc_se;
  logic                    acc_rw;
  logic [ADDR_WIDTH-1:0]   a0, a1, a2, a3;
  logic [7:0]              rb0, rb1, rb2, rb3;
  logic [31:0]             load_val;
  logic                    do_access;

  // Address bits above the decoded range are deliberately dropped (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[31:ADDR_WIDTH];

  // Classify the live request: illegal size or an address not aligned to it.
  always_comb begin
    misaligned_req = 1'b0;
    case (mem_size)
      2'b00:   misaligned_req = 1'b0;
      2'b01:   misaligned_req = address[0];
      2'b10:   misaligned_req = (address[1:0] != 2'b00);
      default: misaligned_req = 1'b1;
    endcase
  end

  // With zero wait states the access happens straight out of IDLE, so the
  // live inputs are used there; otherwise the latched copies drive it.
  always_comb begin
    if (state == IDLE) begin
      acc_addr = address[ADDR_WIDTH-1:0];
      acc_data = data_in;
      acc_size = mem_size;
      acc_se   = mem_se;
      acc_rw   = mem_rw;
    end else begin
      acc_addr = lat_addr;
      acc_data = lat_data;
      acc_size = lat_size;
      acc_se   = lat_se;
      acc_rw   = lat_rw;
    end
  end

  assign a0  = acc_addr;
  assign a1  = acc_addr + ADDR_WIDTH'(1);
  assign a2  = acc_addr + ADDR_WIDTH'(2);
  assign a3  = acc_addr + ADDR_WIDTH'(3);
  assign rb0 = ram[a0];
  assign rb1 = ram[a1];
  assign rb2 = ram[a2];
  assign rb3 = ram[a3];

  // The access is committed on the edge that moves the FSM into DONE.
  assign do_access = ((state == WAIT) && (wait_cnt == '0)) ||
                     ((state == IDLE) && mem_enable && !misaligned_req &&
                      (WAIT_STATES == 0));

  // Big-endian load assembly with sign or zero extension for sub-word sizes.
  always_comb begin
    load_val = {rb0, rb1, rb2, rb3};
    case (acc_size)
      2'b00:   load_val = {{24{acc_se & rb0[7]}}, rb0};
      2'b01:   load_val = {{16{acc_se & rb0[7]}}, rb0, rb1};
      default: load_val = {rb0, rb1, rb2, rb3};
    endcase
  end

  // RAM write port; never cleared, and blocked while reset is asserted so an
  // abandoned request cannot commit.
  always_ff @(posedge clk) begin
    if (reset && do_access && acc_rw) begin
      case (acc_size)
        2'b00: begin
          ram[a0] <= acc_data[7:0];
        end
        2'b01: begin
          ram[a0] <= acc_data[15:8];
          ram[a1] <= acc_data[7:0];
        end
        2'b10: begin
          ram[a0] <= acc_data[31:24];
          ram[a1] <= acc_data[23:16];
          ram[a2] <= acc_data[15:8];
          ram[a3] <= acc_data[7:0];
        end
        default: ;
      endcase
    end
  end

  // Request FSM with registered handshake outputs and load result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      data_out  <= '0;
      mem_busy  <= 1'b0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_size  <= 2'b00;
      lat_se    <= 1'b0;
      lat_rw    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          mem_busy  <= 1'b0;
          if (mem_enable) begin
            lat_addr <= address[ADDR_WIDTH-1:0];
            lat_data <= data_in;
            lat_size <= mem_size;
            lat_se   <= mem_se;
            lat_rw   <= mem_rw;
            if (misaligned_req) begin
              state     <= ERR;
              mem_ready <= 1'b1;
              mem_err   <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state    <= WAIT;
              mem_busy <= 1'b1;
              wait_cnt <= CW'(WAIT_STATES - 1);
            end else begin
              state     <= DONE;
              mem_ready <= 1'b1;
              if (!mem_rw) begin
                data_out <= load_val;
              end
            end
          end
        end
        WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CW'(1);
          end else begin
            state     <= DONE;
            mem_busy  <= 1'b0;
            mem_ready <= 1'b1;
            if (!lat_rw) begin
              data_out <= load_val;
            end
          end
        end
        DONE, ERR: begin
          state     <= IDLE;
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          mem_busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Directed and randomized checks of data_mem_responder against a byte-array
// reference model of a big-endian RAM with per-request handshake timing.

module tb_data_mem_responder;

  localparam int AW    = 9;
  localparam int WS    = 2;
  localparam int DEPTH = 2 ** AW;

  logic        clk;
  logic        reset;
  logic        mem_enable;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic        mem_se;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        mem_busy;
  logic        mem_ready;
  logic        mem_err;

  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] exp_dout;
  int          checks;
  int          errors;

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_enable (mem_enable),
    .mem_rw     (mem_rw),
    .mem_size   (mem_size),
    .mem_se     (mem_se),
    .address    (address),
    .data_in    (data_in),
    .data_out   (data_out),
    .mem_busy   (mem_busy),
    .mem_ready  (mem_ready),
    .mem_err    (mem_err)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one request in the current IDLE cycle, scrambles the inputs while
  // it is in flight, and checks the handshake and result against the model.
  task automatic applyStimulus(input logic rw, input logic [1:0] size,
                               input logic se, input logic [31:0] addr,
                               input logic [31:0] din);
    int unsigned base;
    int unsigned nbytes;
    logic        bad;
    logic [31:0] val;
    logic [31:0] mask;

    base   = addr % DEPTH;
    nbytes = 1 << size;
    bad    = (size == 2'b11) || ((addr % nbytes) != 0);

    if (!bad) begin
      if (rw) begin
        for (int k = 0; k < int'(nbytes); k++)
          ref_mem[(base + k) % DEPTH] = din[8*(int'(nbytes)-1-k) +: 8];
      end else begin
        val = 32'd0;
        for (int k = 0; k < int'(nbytes); k++)
          val = (val << 8) | 32'(ref_mem[(base + k) % DEPTH]);
        if (nbytes < 4 && se && val[8*nbytes-1]) begin
          mask = (32'd1 << (8*nbytes)) - 32'd1;
          val  = val | ~mask;
        end
        exp_dout = val;
      end
    end

    mem_enable = 1'b1;
    mem_rw     = rw;
    mem_size   = size;
    mem_se     = se;
    address    = addr;
    data_in    = din;
    nextCycle();
    mem_enable = 1'b0;
    mem_rw     = 1'($urandom);
    mem_size   = 2'($urandom);
    mem_se     = 1'($urandom);
    address    = $urandom;
    data_in    = $urandom;

    if (bad) begin
      checkOutput("err_ready", 32'(mem_ready), 32'd1);
      checkOutput("err_flag",  32'(mem_err),   32'd1);
      checkOutput("err_busy",  32'(mem_busy),  32'd0);
      checkOutput("err_dout",  data_out,       exp_dout);
    end else begin
      for (int i = 0; i < WS; i++) begin
        checkOutput("wait_busy",  32'(mem_busy),  32'd1);
        checkOutput("wait_ready", 32'(mem_ready), 32'd0);
        nextCycle();
      end
      checkOutput("done_ready", 32'(mem_ready), 32'd1);
      checkOutput("done_err",   32'(mem_err),   32'd0);
      checkOutput("done_busy",  32'(mem_busy),  32'd0);
      checkOutput("done_dout",  data_out,       exp_dout);
    end
    nextCycle();
    checkOutput("idle_ready", 32'(mem_ready), 32'd0);
  endtask

  // Directed test plan followed by randomized traffic.
  initial begin
    checks     = 0;
    errors     = 0;
    exp_dout   = 32'd0;
    reset      = 1'b0;
    mem_enable = 1'b1;
    mem_rw     = 1'b1;
    mem_size   = 2'b10;
    mem_se     = 1'b0;
    address    = 32'h10;
    data_in    = 32'hCAFEF00D;

    // Reset held with a pending request.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy",  32'(mem_busy),  32'd0);
    checkOutput("rst_ready", 32'(mem_ready), 32'd0);
    checkOutput("rst_err",   32'(mem_err),   32'd0);
    checkOutput("rst_dout",  data_out,       32'd0);
    mem_enable = 1'b0;
    reset      = 1'b1;
    nextCycle();
    checkOutput("post_rst_busy",  32'(mem_busy),  32'd0);
    checkOutput("post_rst_ready", 32'(mem_ready), 32'd0);

    // Word store/load and sized loads.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkOutput("plan_word", data_out, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    checkOutput("plan_byte_se", data_out, 32'hFFFFFFDE);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    checkOutput("plan_byte_ze", data_out, 32'h000000DE);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    checkOutput("plan_half_se", data_out, 32'hFFFFBEEF);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    checkOutput("plan_half_ze", data_out, 32'h0000BEEF);

    // Sub-word stores.
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000005A);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkOutput("plan_store_byte", data_out, 32'hDEADBE5A);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h10, 32'h00001234);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkOutput("plan_store_half", data_out, 32'h1234BE5A);

    // Misaligned and illegal requests.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFFFFFF);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    checkOutput("plan_err_dout", data_out, 32'h1234BE5A);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkOutput("plan_err_nowrite", data_out, 32'h1234BE5A);

    // Reset on the commit edge abandons the store.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'h0);
    mem_enable = 1'b1;
    mem_rw     = 1'b1;
    mem_size   = 2'b10;
    mem_se     = 1'b0;
    address    = 32'h20;
    data_in    = 32'h11111111;
    nextCycle();
    mem_enable = 1'b0;
    nextCycle();
    reset = 1'b0;
    nextCycle();
    exp_dout = 32'd0;
    checkOutput("midrst_ready", 32'(mem_ready), 32'd0);
    checkOutput("midrst_busy",  32'(mem_busy),  32'd0);
    checkOutput("midrst_dout",  data_out,       32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("midrst_no_ready", 32'(mem_ready), 32'd0);
    end
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    checkOutput("midrst_nowrite", data_out, 32'h00000000);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h20 + DEPTH, 32'h0);
    checkOutput("wrap_load", data_out, 32'h00000000);

    // Randomized traffic inside a fully initialized window 0x40..0x7F,
    // with random upper address bits to exercise the wrap.
    for (int w = 0; w < 16; w++)
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h40 + 32'(4*w), $urandom);
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom & ~32'(DEPTH - 1)) | (32'h40 + 32'($urandom_range(0, 63)));
      applyStimulus(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
